// File: rtl/svm_classifier_param.sv
// Parametrised SVM classifier: cubic polynomial kernel over a BRAM-held image, argmax over classes.
// Define SVM_SCORE_OUT_EN to expose best_score and per-class class_score/score_valid.
module svm_classifier_param #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned IMG_LEN     = 784,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SV_W        = 10,
  parameter int unsigned KSHIFT      = 4,
  localparam int unsigned AW         = $clog2(IMG_LEN),
  localparam int unsigned CLW        = ($clog2(NUM_CLASSES) > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int unsigned ACC_W      = 2 * WIDTH + $clog2(IMG_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  output logic             interrupt,
  output logic [1:0]       irq_cause,
  output logic [CLW-1:0]   cl_num,
  output logic             cl_valid,
  input  logic [WIDTH-1:0] sdata,
  input  logic             svalid,
  output logic             sready,
  input  logic [WIDTH-1:0] bdata_in,
  output logic [WIDTH-1:0] bdata_out,
  output logic [AW-1:0]    baddr,
  output logic             en,
  output logic             we
`ifdef SVM_SCORE_OUT_EN
  ,
  output logic [ACC_W-1:0] best_score,
  output logic [ACC_W-1:0] class_score,
  output logic             score_valid
`endif
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StLoadImg = 4'd1;
  localparam logic [3:0] StHdr     = 4'd2;
  localparam logic [3:0] StDot     = 4'd3;
  localparam logic [3:0] StDrain   = 4'd4;
  localparam logic [3:0] StK1      = 4'd5;
  localparam logic [3:0] StK2      = 4'd6;
  localparam logic [3:0] StK3      = 4'd7;
  localparam logic [3:0] StLambda  = 4'd8;
  localparam logic [3:0] StBias    = 4'd9;
  localparam logic [3:0] StDone    = 4'd10;

  logic [3:0]              state_q, state_d;
  logic [AW-1:0]           i_q, i_d;
  logic [CLW-1:0]          class_q, class_d;
  logic [SV_W-1:0]         svcnt_q, svcnt_d;
  logic [SV_W-1:0]         sv_q, sv_d;
  logic signed [ACC_W-1:0] dot_q, dot_d;
  logic signed [ACC_W-1:0] t_q, t_d;
  logic signed [ACC_W-1:0] p_q, p_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] best_q, best_d;
  logic [CLW-1:0]          num_q, num_d;
  logic [CLW-1:0]          cl_num_q, cl_num_d;
  logic                    cl_valid_q, cl_valid_d;
  logic                    irq_q, irq_d;
  logic [1:0]              cause_q, cause_d;
  logic [WIDTH-1:0]        sdata_q, sdata_d;
  logic                    flag_q, flag_d;
`ifdef SVM_SCORE_OUT_EN
  logic [ACC_W-1:0]        best_score_q, best_score_d;
  logic [ACC_W-1:0]        class_score_q, class_score_d;
  logic                    score_valid_q, score_valid_d;
`endif

  logic                    xfer;
  logic signed [ACC_W-1:0] sd_ext, bd_ext, sq_ext, mac, score;
  logic [AW-1:0]           i_inc;
  logic [SV_W-1:0]         sv_inc;
  logic                    i_last, class_last;

  assign sready     = (state_q == StLoadImg) || (state_q == StHdr) || (state_q == StDot) ||
                      (state_q == StLambda) || (state_q == StBias);
  assign xfer       = svalid && sready;
  assign sd_ext     = ACC_W'($signed(sdata));
  assign bd_ext     = ACC_W'($signed(bdata_in));
  assign sq_ext     = ACC_W'($signed(sdata_q));
  assign mac        = bd_ext * sq_ext;
  assign score      = acc_q + sd_ext;
  assign i_inc      = i_q + AW'(1);
  assign sv_inc     = sv_q + SV_W'(1);
  assign i_last     = (i_q == AW'(IMG_LEN - 1));
  assign class_last = (class_q == CLW'(NUM_CLASSES - 1));

  assign ready     = (state_q == StIdle);
  assign interrupt = irq_q;
  assign irq_cause = cause_q;
  assign cl_num    = cl_num_q;
  assign cl_valid  = cl_valid_q;
`ifdef SVM_SCORE_OUT_EN
  assign best_score  = best_score_q;
  assign class_score = class_score_q;
  assign score_valid = score_valid_q;
`endif

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    class_d    = class_q;
    svcnt_d    = svcnt_q;
    sv_d       = sv_q;
    dot_d      = dot_q;
    t_d        = t_q;
    p_d        = p_q;
    acc_d      = acc_q;
    best_d     = best_q;
    num_d      = num_q;
    cl_num_d   = cl_num_q;
    cl_valid_d = cl_valid_q;
    irq_d      = 1'b0;
    cause_d    = cause_q;
    sdata_d    = sdata_q;
    flag_d     = 1'b0;
`ifdef SVM_SCORE_OUT_EN
    best_score_d  = best_score_q;
    class_score_d = class_score_q;
    score_valid_d = 1'b0;
`endif
    en         = 1'b0;
    we         = 1'b0;
    baddr      = '0;
    bdata_out  = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          cl_valid_d = 1'b0;
          irq_d      = 1'b1;
          cause_d    = 2'd0;
          i_d        = '0;
          state_d    = StLoadImg;
        end
      end
      StLoadImg: begin
        if (xfer) begin
          en        = 1'b1;
          we        = 1'b1;
          baddr     = i_q;
          bdata_out = sdata;
          i_d       = i_inc;
          if (i_last) begin
            class_d = '0;
            irq_d   = 1'b1;
            cause_d = 2'd1;
            state_d = StHdr;
          end
        end
      end
      StHdr: begin
        if (xfer) begin
          svcnt_d = sdata[SV_W-1:0];
          sv_d    = '0;
          acc_d   = '0;
          if (sdata[SV_W-1:0] == '0) begin
            irq_d   = 1'b1;
            cause_d = 2'd2;
            state_d = StBias;
          end else begin
            i_d     = '0;
            dot_d   = '0;
            state_d = StDot;
          end
        end
      end
      StDot: begin
        // Accumulate the word read last cycle while issuing the next read.
        if (flag_q) dot_d = dot_q + mac;
        if (xfer) begin
          en      = 1'b1;
          baddr   = i_q;
          sdata_d = sdata;
          flag_d  = 1'b1;
          i_d     = i_inc;
          if (i_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (flag_q) dot_d = dot_q + mac;
        state_d = StK1;
      end
      StK1: begin
        t_d     = dot_q >>> KSHIFT;
        state_d = StK2;
      end
      StK2: begin
        p_d     = t_q * t_q;
        state_d = StK3;
      end
      StK3: begin
        p_d     = p_q * t_q;
        state_d = StLambda;
      end
      StLambda: begin
        if (xfer) begin
          acc_d = acc_q + p_q * sd_ext;
          sv_d  = sv_inc;
          if (sv_inc == svcnt_q) begin
            irq_d   = 1'b1;
            cause_d = 2'd2;
            state_d = StBias;
          end else begin
            i_d     = '0;
            dot_d   = '0;
            state_d = StDot;
          end
        end
      end
      StBias: begin
        if (xfer) begin
          // Strict compare keeps the lower index on ties.
          if ((class_q == '0) || (score > best_q)) begin
            best_d = score;
            num_d  = class_q;
          end
`ifdef SVM_SCORE_OUT_EN
          class_score_d = score;
          score_valid_d = 1'b1;
`endif
          if (class_last) begin
            state_d = StDone;
          end else begin
            class_d = class_q + CLW'(1);
            irq_d   = 1'b1;
            cause_d = 2'd1;
            state_d = StHdr;
          end
        end
      end
      StDone: begin
        cl_num_d   = num_q;
        cl_valid_d = 1'b1;
        irq_d      = 1'b1;
        cause_d    = 2'd3;
`ifdef SVM_SCORE_OUT_EN
        best_score_d = best_q;
`endif
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      i_q        <= '0;
      class_q    <= '0;
      svcnt_q    <= '0;
      sv_q       <= '0;
      dot_q      <= '0;
      t_q        <= '0;
      p_q        <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      num_q      <= '0;
      cl_num_q   <= '0;
      cl_valid_q <= 1'b0;
      irq_q      <= 1'b0;
      cause_q    <= '0;
      sdata_q    <= '0;
      flag_q     <= 1'b0;
`ifdef SVM_SCORE_OUT_EN
      best_score_q  <= '0;
      class_score_q <= '0;
      score_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      class_q    <= class_d;
      svcnt_q    <= svcnt_d;
      sv_q       <= sv_d;
      dot_q      <= dot_d;
      t_q        <= t_d;
      p_q        <= p_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      num_q      <= num_d;
      cl_num_q   <= cl_num_d;
      cl_valid_q <= cl_valid_d;
      irq_q      <= irq_d;
      cause_q    <= cause_d;
      sdata_q    <= sdata_d;
      flag_q     <= flag_d;
`ifdef SVM_SCORE_OUT_EN
      best_score_q  <= best_score_d;
      class_score_q <= class_score_d;
      score_valid_q <= score_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_svm_classifier_param.sv
// Randomised self-checking bench for svm_classifier_param with a BRAM model and a
// score-level reference model of the classification.
module tb_svm_classifier_param;
  localparam int WIDTH = 16;
  localparam int IMG_LEN = 4;
  localparam int NC = 3;
  localparam int KSHIFT = 0;
  localparam int ACC_W = 2 * WIDTH + $clog2(IMG_LEN);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ready, interrupt, cl_valid, sready, en, we;
  logic [1:0] irq_cause;
  logic [1:0] cl_num;
  logic [WIDTH-1:0] sdata = '0;
  logic svalid = 1'b0;
  logic [WIDTH-1:0] bdata_in = '0;
  logic [WIDTH-1:0] bdata_out;
  logic [1:0] baddr;
`ifdef SVM_SCORE_OUT_EN
  logic [ACC_W-1:0] best_score, class_score;
  logic score_valid;
`endif

  svm_classifier_param #(
    .WIDTH(WIDTH), .IMG_LEN(IMG_LEN), .NUM_CLASSES(NC), .SV_W(10), .KSHIFT(KSHIFT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .interrupt(interrupt),
    .irq_cause(irq_cause), .cl_num(cl_num), .cl_valid(cl_valid), .sdata(sdata),
    .svalid(svalid), .sready(sready), .bdata_in(bdata_in), .bdata_out(bdata_out),
    .baddr(baddr), .en(en), .we(we)
`ifdef SVM_SCORE_OUT_EN
    , .best_score(best_score), .class_score(class_score), .score_valid(score_valid)
`endif
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [IMG_LEN];
  always @(posedge clk) begin
    if (en && we) mem[baddr] <= bdata_out;
    if (en) bdata_in <= mem[baddr];
  end

  int checks = 0;
  int failures = 0;
  int causes[$];
  int bram_viol = 0;

  always @(negedge clk) begin
    if (interrupt) causes.push_back(int'(irq_cause));
    if (en && !(svalid && sready)) bram_viol++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    logic signed [ACC_W-1:0] t;
    t = x[ACC_W-1:0];
    return longint'(t);
  endfunction

  function automatic int rnd16();
    logic signed [15:0] v;
    int r;
    if ($urandom_range(0, 1) == 0) begin
      r = int'($urandom_range(0, 15)) - 8;
      return r;
    end
    v = 16'($urandom);
    return int'(v);
  endfunction

  int stream[$];
  int exp_num;
  longint exp_best;

  // mode 0: basic, 1: all-tie, 2: class 1 empty with big bias, 3: random
  task automatic build(input int mode);
    int img[IMG_LEN];
    int hdr, v, lam, bias;
    longint dot, t, p, acc, score;
    stream.delete();
    for (int k = 0; k < IMG_LEN; k++) begin
      img[k] = (mode < 3) ? k + 1 : rnd16();
      stream.push_back(img[k]);
    end
    exp_num = 0;
    exp_best = 0;
    for (int c = 0; c < NC; c++) begin
      if (mode == 2 && c == 1) hdr = 0;
      else if (mode < 3) hdr = 1;
      else hdr = int'($urandom_range(0, 2));
      stream.push_back(hdr);
      acc = 0;
      for (int s = 0; s < hdr; s++) begin
        dot = 0;
        for (int k = 0; k < IMG_LEN; k++) begin
          v = (mode < 3) ? 1 : rnd16();
          stream.push_back(v);
          dot = wrap(dot + longint'(img[k]) * longint'(v));
        end
        t = wrap(dot >>> KSHIFT);
        p = wrap(wrap(t * t) * t);
        lam = (mode == 1) ? 5 : (mode < 3) ? c + 1 : rnd16();
        stream.push_back(lam);
        acc = wrap(acc + wrap(p * longint'(lam)));
      end
      if (mode == 1) bias = 7;
      else if (mode == 2) bias = (c == 1) ? 30000 : 0;
      else if (mode == 0) bias = 0;
      else bias = rnd16();
      stream.push_back(bias);
      score = wrap(acc + longint'(bias));
      if (c == 0 || score > exp_best) begin
        exp_best = score;
        exp_num = c;
      end
    end
  endtask

  task automatic drive(input int nwords, input int gap, input int sidx, output bit ok);
    ok = 1'b1;
    for (int n = 0; n < nwords; n++) begin
      int waitc = 0;
      bit done = 1'b0;
      while (!done) begin
        @(negedge clk);
        start = (n == sidx);
        if ((gap == 1 && waitc == 0) || (gap == 2 && $urandom_range(0, 3) == 0)) begin
          svalid = 1'b0;
          sdata = '0;
        end else begin
          sdata = 16'(stream[n]);
          svalid = 1'b1;
          #1;
          if (sready) done = 1'b1;
        end
        waitc++;
        if (!done && waitc > 200) begin
          check("stream_timeout", 0, 1);
          ok = 1'b0;
          svalid = 1'b0;
          start = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    svalid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run(input int mode, input int gap, input int sidx, input string name);
    bit ok;
    int w;
    int exp_causes[$];
    build(mode);
    causes.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive(stream.size(), gap, sidx, ok);
    if (!ok) return;
    w = 0;
    while (!cl_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({name, "_result_timeout"}, longint'(cl_valid), 1);
    check({name, "_cl_num"}, longint'(cl_num), longint'(exp_num));
`ifdef SVM_SCORE_OUT_EN
    check({name, "_best_score"}, wrap(longint'(best_score)), exp_best);
`endif
    repeat (3) @(negedge clk);
    exp_causes.push_back(0);
    for (int c = 0; c < NC; c++) begin
      exp_causes.push_back(1);
      exp_causes.push_back(2);
    end
    exp_causes.push_back(3);
    check({name, "_ncauses"}, longint'(causes.size()), longint'(exp_causes.size()));
    for (int k = 0; k < exp_causes.size() && k < causes.size(); k++)
      check($sformatf("%s_cause%0d", name, k), longint'(causes[k]), longint'(exp_causes[k]));
    check({name, "_ready_after"}, longint'(ready), 1);
    check({name, "_cl_valid_held"}, longint'(cl_valid), 1);
  endtask

  initial begin
    bit ok;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", longint'(ready), 1);
    check("rst_interrupt", longint'(interrupt), 0);
    check("rst_irq_cause", longint'(irq_cause), 0);
    check("rst_cl_num", longint'(cl_num), 0);
    check("rst_cl_valid", longint'(cl_valid), 0);
    check("rst_sready", longint'(sready), 0);
    check("rst_en", longint'(en), 0);
    check("rst_we", longint'(we), 0);
    check("rst_baddr", longint'(baddr), 0);
    check("rst_bdata_out", longint'(bdata_out), 0);

    run(0, 0, -1, "base");
    run(1, 0, -1, "tie");
    run(2, 0, -1, "hdr0");
    run(0, 1, -1, "toggle");
    run(0, 0, IMG_LEN + 1 + IMG_LEN, "start_lambda");

    // Abort in the middle of class 1's dot product.
    build(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive(IMG_LEN + (IMG_LEN + 3) + 1 + 2, 0, -1, ok);
    #1;
    check("mid_ready", longint'(ready), 0);
    check("mid_sready", longint'(sready), 1);
    reset = 1'b1;
    #1;
    check("abort_ready", longint'(ready), 1);
    check("abort_sready", longint'(sready), 0);
    check("abort_cl_valid", longint'(cl_valid), 0);
    check("abort_en", longint'(en), 0);
    @(negedge clk);
    reset = 1'b0;
    run(0, 0, -1, "after_abort");

    for (int r = 0; r < 6; r++) run(3, 2, -1, $sformatf("rnd%0d", r));

    check("bram_read_on_xfer_only", longint'(bram_viol), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
